// File: rtl/shift_add_multi_param_pkg.sv
`default_nettype none
// Shared encodings for iterative arithmetic units: FSM states and a
// two's-complement helper (also intended for a future divider).
package shift_add_multi_param_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Callers zero-extend into MAX_W bits and cast the result back to their width.
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
    return ~v + MAX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_multi_param_step.sv
`default_nettype none
// shift_add_step: one combinational partial-product step of the shift-add
// multiplier; the upper half accumulates, the lower half holds the multiplier.
module shift_add_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] w_sum;

  // The carry out of the add becomes the new MSB after the right shift.
  assign w_sum = acc_i[0] ? ({1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i})
                          :  {1'b0, acc_i[2*WIDTH-1:WIDTH]};

  assign acc_o = {w_sum, acc_i[WIDTH-1:1]};

endmodule
`default_nettype wire

// File: rtl/shift_add_multi_param.sv
`default_nettype none
// shift_add_multi_param: iterative WIDTH x WIDTH shift-add multiplier with
// optional signed operation, one partial product per clock.
module shift_add_multi_param
  import shift_add_multi_param_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit SIGNED_EN = 1'b1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 fin,
  output logic [CW-1:0]        count,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    product_q, product_d;

  logic             w_sflag;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [PW-1:0]    w_step;
  logic [PW-1:0]    w_result;

  assign w_sflag = is_signed & SIGNED_EN;

  // -2^(WIDTH-1) negates to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign w_mag_a = (w_sflag && multiplicand[WIDTH-1])
                 ? WIDTH'(twos_neg(MAX_W'(multiplicand))) : multiplicand;
  assign w_mag_b = (w_sflag && multiplier[WIDTH-1])
                 ? WIDTH'(twos_neg(MAX_W'(multiplier))) : multiplier;

  assign w_result = neg_q ? PW'(twos_neg(MAX_W'(w_step))) : w_step;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .acc_o   (w_step)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    neg_d     = neg_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          mcand_d = w_mag_a;
          acc_d   = {{WIDTH{1'b0}}, w_mag_b};
          neg_d   = w_sflag & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          count_d = '0;
        end
      end
      CALC: begin
        acc_d   = w_step;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d   = DONE;
          product_d = w_result;
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      neg_q     <= neg_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign fin     = (state_q == DONE);
  assign count   = count_q;
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multi_param.sv
`default_nettype none
// Bench for shift_add_multi_param: WIDTH=4 signed-capable instance plus a
// WIDTH=8 unsigned-only instance, checked against an integer-arithmetic model.
module tb_shift_add_multi_param;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic       start, is_signed;
  logic [3:0] a, b;
  logic       busy, fin;
  logic [2:0] count;
  logic [7:0] product;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, fin8;
  logic [3:0]  count8;
  logic [15:0] product8;

  int n_vec = 0;
  int n_err = 0;

  shift_add_multi_param #(.WIDTH(4), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .is_signed(is_signed),
    .multiplicand(a), .multiplier(b), .busy(busy), .fin(fin),
    .count(count), .product(product)
  );

  shift_add_multi_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk(clk), .n_rst(n_rst), .start(start8), .is_signed(sgn8),
    .multiplicand(a8), .multiplier(b8), .busy(busy8), .fin(fin8),
    .count(count8), .product(product8)
  );

  // Reference: interpret operands as integers and truncate the true product.
  function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y, input logic s);
    int xv, yv;
    xv = int'(x);
    yv = int'(y);
    if (s && xv >= 8) xv = xv - 16;
    if (s && yv >= 8) yv = yv - 16;
    return 8'(xv * yv);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one op, scrambles inputs while busy, returns product and fin latency in edges.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic s,
                        output logic [7:0] p, output int lat);
    a = x; b = y; is_signed = s; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!fin && lat < 20) begin
      a = 4'($urandom); b = 4'($urandom); is_signed = 1'($urandom);
      tick();
      lat++;
    end
    if (!fin) lat = -1;
    p = product;
    tick();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    #3;
    n_vec++;
    if ({busy, fin, count, product} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_w4 got busy=%b fin=%b count=%0d product=%h want all 0", busy, fin, count, product);
    end
    n_vec++;
    if ({busy8, fin8, count8, product8} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_w8 got busy=%b fin=%b count=%0d product=%h want all 0", busy8, fin8, count8, product8);
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_timing();
    a = 4'd6; b = 4'd7; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || fin !== 1'b0 || count !== 3'd0) begin
      n_err++;
      $display("FAIL start_edge got busy=%b fin=%b count=%0d want 1 0 0", busy, fin, count);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (count !== 3'(i) || busy !== 1'b1 || fin !== (i == 4)) begin
        n_err++;
        $display("FAIL step%0d got count=%0d busy=%b fin=%b want %0d 1 %b", i, count, busy, fin, i, (i == 4));
      end
    end
    n_vec++;
    if (product !== 8'h2A) begin
      n_err++;
      $display("FAIL mul_6x7 got %h want 2a", product);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (busy !== 1'b0 || fin !== 1'b0 || count !== 3'd0 || product !== 8'h2A) begin
        n_err++;
        $display("FAIL idle_hold%0d got busy=%b fin=%b count=%0d product=%h want 0 0 0 2a", i, busy, fin, count, product);
      end
    end
  endtask

  task automatic test_signed();
    logic [7:0] p;
    int lat;
    run_op(4'hD, 4'h5, 1'b1, p, lat);
    n_vec++;
    if (p !== 8'hF1 || lat !== 4) begin
      n_err++;
      $display("FAIL signed_m3x5 got %h lat=%0d want f1 lat=4", p, lat);
    end
    run_op(4'hD, 4'h5, 1'b0, p, lat);
    n_vec++;
    if (p !== 8'h41 || lat !== 4) begin
      n_err++;
      $display("FAIL unsigned_13x5 got %h lat=%0d want 41 lat=4", p, lat);
    end
  endtask

  task automatic test_boundaries();
    logic [3:0] xs [6] = '{4'h8, 4'h8, 4'hF, 4'h0, 4'h0, 4'hF};
    logic [3:0] ys [6] = '{4'h8, 4'h7, 4'hF, 4'h9, 4'h9, 4'hF};
    logic       ss [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [6] = '{8'h40, 8'hC8, 8'hE1, 8'h00, 8'h00, 8'h01};
    logic [7:0] p;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(xs[i], ys[i], ss[i], p, lat);
      n_vec++;
      if (p !== es[i] || lat !== 4) begin
        n_err++;
        $display("FAIL boundary%0d %h*%h s=%b got %h lat=%0d want %h lat=4", i, xs[i], ys[i], ss[i], p, lat, es[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] x, y;
    logic       s;
    logic [7:0] p, e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      x = 4'($urandom); y = 4'($urandom); s = 1'($urandom);
      e = model4(x, y, s);
      run_op(x, y, s, p, lat);
      n_vec++;
      if (p !== e || lat !== 4) begin
        n_err++;
        $display("FAIL random%0d %h*%h s=%b got %h lat=%0d want %h lat=4", i, x, y, s, p, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prev, p1, p2;
    int f1, f2, nfin;
    a = 4'd6; b = 4'd7; is_signed = 1'b0; start = 1'b1;
    prev = product;
    nfin = 0; f1 = -1; f2 = -1; p1 = '0; p2 = '0;
    for (int c = 0; c < 40 && nfin < 2; c++) begin
      tick();
      if (c == 1) begin
        a = 4'd3; b = 4'hD; is_signed = 1'b1;
      end
      n_vec++;
      if (product !== prev && !fin) begin
        n_err++;
        $display("FAIL b2b_product_glitch cycle%0d got %h want %h", c, product, prev);
      end
      prev = product;
      if (fin) begin
        if (nfin == 0) begin f1 = c; p1 = product; end
        else           begin f2 = c; p2 = product; end
        nfin++;
      end
    end
    start = 1'b0;
    n_vec++;
    if (p1 !== 8'h2A) begin
      n_err++;
      $display("FAIL b2b_first got %h want 2a", p1);
    end
    n_vec++;
    if (p2 !== model4(4'd3, 4'hD, 1'b1)) begin
      n_err++;
      $display("FAIL b2b_second got %h want %h", p2, model4(4'd3, 4'hD, 1'b1));
    end
    n_vec++;
    if (f1 < 0 || f2 - f1 !== 6) begin
      n_err++;
      $display("FAIL b2b_period got %0d want 6", f2 - f1);
    end
    for (int c = 0; c < 12 && busy; c++) tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] p;
    int lat;
    a = 4'd5; b = 4'd5; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_vec++;
    if (count !== 3'd2 || product === 8'h00) begin
      n_err++;
      $display("FAIL pre_reset got count=%0d product=%h want 2 nonzero", count, product);
    end
    #2 n_rst = 1'b0;
    #1;
    n_vec++;
    if ({busy, fin, count, product} !== 13'd0) begin
      n_err++;
      $display("FAIL async_reset got busy=%b fin=%b count=%0d product=%h want all 0", busy, fin, count, product);
    end
    #2 n_rst = 1'b1;
    tick();
    run_op(4'h9, 4'h4, 1'b1, p, lat);
    n_vec++;
    if (p !== 8'hE4 || lat !== 4) begin
      n_err++;
      $display("FAIL post_reset_op got %h lat=%0d want e4 lat=4", p, lat);
    end
  endtask

  task automatic test_w8_unsigned_only();
    logic [7:0]  xs [3] = '{8'hFF, 8'h80, 8'hC3};
    logic [7:0]  ys [3] = '{8'hFF, 8'h02, 8'h5A};
    logic [15:0] e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      a8 = xs[i]; b8 = ys[i]; sgn8 = 1'b1; start8 = 1'b1;
      e = 16'(int'(xs[i]) * int'(ys[i]));
      tick();
      start8 = 1'b0;
      lat = 0;
      while (!fin8 && lat < 30) begin
        tick();
        lat++;
      end
      n_vec++;
      if (!fin8 || product8 !== e || lat !== 8) begin
        n_err++;
        $display("FAIL w8_op%0d got %h lat=%0d want %h lat=8", i, product8, lat, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_timing();
    test_signed();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_w8_unsigned_only();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
